reg_dst_tracker: RTL and testbench

//   Parametrised successor to the RegDst destination mux for the multicycle MIPS core.

---
 rtl/reg_dst_tracker.sv | 123 ++++++++++++
 tb/tb_reg_dst_tracker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_dst_tracker.sv
// Write-back destination tracker for the multicycle MIPS core.
// Decodes the RegDst select into a register index at issue and holds issued
// indices in an in-order FIFO until they retire. rs/rt operands of the next
// instruction are checked against the in-flight entries for RAW hazards.
module reg_dst_tracker #(
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SP_IDX   = 29,
    parameter int unsigned RA_IDX   = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue,
    input  logic [1:0]                sel,
    input  logic [REG_BITS-1:0]       rt,
    input  logic [REG_BITS-1:0]       rd,
    input  logic                      retire,
    input  logic [REG_BITS-1:0]       q_rs,
    input  logic [REG_BITS-1:0]       q_rt,
    output logic [REG_BITS-1:0]       dst_out,
    output logic [REG_BITS-1:0]       wb_dst,
    output logic                      hazard_rs,
    output logic                      hazard_rt,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic                      err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [REG_BITS-1:0] mem_q   [DEPTH];
    logic [REG_BITS-1:0] mem_d   [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [REG_BITS-1:0] dst_out_q, dst_out_d;
    logic                err_q, err_d;

    logic [REG_BITS-1:0] sel_idx;
    logic                issue_ok, retire_ok;

    // Destination select: all four codes map to distinct sources.
    always_comb begin
        sel_idx = '0;
        unique case (sel)
            2'b00: sel_idx = REG_BITS'(SP_IDX);
            2'b01: sel_idx = rt;
            2'b10: sel_idx = REG_BITS'(RA_IDX);
            2'b11: sel_idx = rd;
            default: sel_idx = '0;
        endcase
    end

    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);
    // A retire in the same cycle frees the head slot, so issue at full is legal then.
    assign issue_ok  = issue && (!full || retire);
    assign retire_ok = retire && !empty;

    // Next-state for FIFO storage, pointers, count, registered outputs.
    always_comb begin
        mem_d     = mem_q;
        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dst_out_d = dst_out_q;
        err_d     = (issue && full && !retire) || (retire && empty);

        // Clear before set: at full with both, head and tail share a slot.
        if (retire_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PtrW'(1);
        end
        if (issue_ok) begin
            mem_d[wr_ptr_q]   = sel_idx;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PtrW'(1);
            dst_out_d         = sel_idx;
        end
        count_d = count_q + CntW'(issue_ok) - CntW'(retire_ok);
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            valid_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dst_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dst_out_q <= dst_out_d;
            err_q     <= err_d;
        end
    end

    // Hazard match over entries valid before the edge; $zero never hazards.
    always_comb begin
        hazard_rs = 1'b0;
        hazard_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (mem_q[i] == q_rs) && (q_rs != '0)) hazard_rs = 1'b1;
            if (valid_q[i] && (mem_q[i] == q_rt) && (q_rt != '0)) hazard_rt = 1'b1;
        end
    end

    assign wb_dst  = mem_q[rd_ptr_q];
    assign dst_out = dst_out_q;
    assign count   = count_q;
    assign err     = err_q;

endmodule

// File: tb/tb_reg_dst_tracker.sv
// Bench for reg_dst_tracker: retire order is checked by a scoreboard monitor,
// status outputs by directed checks after each clock edge.
module tb_reg_dst_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue, retire;
    logic [1:0] sel;
    logic [4:0] rt, rd, q_rs, q_rt;
    logic [4:0] dst_out, wb_dst;
    logic       hazard_rs, hazard_rt, full, empty, err;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    // Expected destination of the current issue, hand-computed by the stimulus.
    int exp_dst;
    int exp_q[$];

    reg_dst_tracker #(
        .REG_BITS(5), .DEPTH(4), .SP_IDX(29), .RA_IDX(31)
    ) dut (
        .clk(clk), .reset(reset), .issue(issue), .sel(sel), .rt(rt), .rd(rd),
        .retire(retire), .q_rs(q_rs), .q_rt(q_rt), .dst_out(dst_out), .wb_dst(wb_dst),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt), .count(count), .full(full),
        .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: retiring head compared with the oldest expected entry,
    // then an accepted issue pushes its expected index.
    always @(negedge clk) begin
        if (!reset) begin
            int sz;
            sz = exp_q.size();
            if (retire && sz > 0) begin
                int e;
                e = exp_q.pop_front();
                chk("wb_dst_order", int'(wb_dst), e);
            end
            if (issue && (sz < 4 || retire)) exp_q.push_back(exp_dst);
        end
    end

    // One cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic drive(input logic iss, input logic [1:0] s, input logic [4:0] rtv,
                         input logic [4:0] rdv, input logic ret, input int e);
        issue = iss; sel = s; rt = rtv; rd = rdv; retire = ret; exp_dst = e;
        @(posedge clk); #1;
        issue = 1'b0; retire = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; issue = 1'b0; retire = 1'b0; sel = 2'b00;
        rt = '0; rd = '0; q_rs = '0; q_rt = '0; exp_dst = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_dst_out", int'(dst_out), 0);
        chk("rst_err", int'(err), 0);

        // Decode of all four select codes
        drive(1, 2'b00, 5'd5, 5'd12, 0, 29); chk("dec_sp", int'(dst_out), 29);
        drive(1, 2'b01, 5'd5, 5'd12, 0, 5);  chk("dec_rt", int'(dst_out), 5);
        drive(1, 2'b10, 5'd5, 5'd12, 0, 31); chk("dec_ra", int'(dst_out), 31);
        drive(1, 2'b11, 5'd5, 5'd12, 0, 12); chk("dec_rd", int'(dst_out), 12);
        chk("fill_count", int'(count), 4);
        chk("fill_full", int'(full), 1);

        // Overflow drops the issue and pulses err
        drive(1, 2'b11, 5'd0, 5'd7, 0, 7);
        chk("ovf_err", int'(err), 1);
        chk("ovf_count", int'(count), 4);
        chk("ovf_dst_out", int'(dst_out), 12);
        drive(0, 2'b00, 5'd0, 5'd0, 0, 0);
        chk("ovf_err_clear", int'(err), 0);

        // Issue with retire at full is accepted
        drive(1, 2'b11, 5'd0, 5'd9, 1, 9);
        chk("full_ir_count", int'(count), 4);
        chk("full_ir_wb", int'(wb_dst), 5);
        chk("full_ir_err", int'(err), 0);
        chk("full_ir_dst_out", int'(dst_out), 9);
        for (int i = 0; i < 4; i++) drive(0, 2'b00, 5'd0, 5'd0, 1, 0);
        chk("drain_empty", int'(empty), 1);

        // Underflow
        do_reset();
        drive(0, 2'b00, 5'd0, 5'd0, 1, 0);
        chk("unf_err", int'(err), 1);
        chk("unf_empty", int'(empty), 1);
        chk("unf_count", int'(count), 0);
        drive(0, 2'b00, 5'd0, 5'd0, 0, 0);
        chk("unf_err_clear", int'(err), 0);

        // Hazard visibility
        q_rs = 5'd8; q_rt = 5'd0;
        issue = 1'b1; sel = 2'b11; rd = 5'd8; exp_dst = 8;
        #2 chk("haz_not_yet", int'(hazard_rs), 0);
        @(posedge clk); #1; issue = 1'b0;
        chk("haz_rs_set", int'(hazard_rs), 1);
        chk("haz_rt_zero", int'(hazard_rt), 0);
        retire = 1'b1;
        #1 chk("haz_in_retire", int'(hazard_rs), 1);
        @(posedge clk); #1; retire = 1'b0;
        chk("haz_rs_clear", int'(hazard_rs), 0);

        // $zero is enqueued but never hazards
        drive(1, 2'b11, 5'd0, 5'd0, 0, 0);
        q_rs = 5'd0; q_rt = 5'd0; #1;
        chk("zero_count", int'(count), 1);
        chk("zero_haz", int'(hazard_rs), 0);
        drive(0, 2'b00, 5'd0, 5'd0, 1, 0);

        // Wrap-around with alternating issue/retire
        for (int i = 1; i <= 10; i++) begin
            drive(1, 2'b11, 5'd0, 5'(i), 0, i);
            chk("wrap_iss_err", int'(err), 0);
            drive(0, 2'b00, 5'd0, 5'd0, 1, 0);
            chk("wrap_ret_err", int'(err), 0);
        end
        chk("wrap_empty", int'(empty), 1);

        // Asynchronous reset mid-operation
        drive(1, 2'b11, 5'd0, 5'd3, 0, 3);
        drive(1, 2'b11, 5'd0, 5'd4, 0, 4);
        drive(1, 2'b01, 5'd6, 5'd0, 0, 6);
        q_rs = 5'd4; q_rt = 5'd6; #1;
        chk("mid_haz_rs", int'(hazard_rs), 1);
        chk("mid_haz_rt", int'(hazard_rt), 1);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_count", int'(count), 0);
        chk("mid_empty", int'(empty), 1);
        chk("mid_dst_out", int'(dst_out), 0);
        chk("mid_haz_rs_clr", int'(hazard_rs), 0);
        chk("mid_haz_rt_clr", int'(hazard_rt), 0);
        chk("mid_err", int'(err), 0);
        @(posedge clk); #1; reset = 1'b0;
        drive(1, 2'b11, 5'd0, 5'd10, 0, 10);
        chk("resume_count", int'(count), 1);
        drive(0, 2'b00, 5'd0, 5'd0, 1, 0);
        chk("resume_empty", int'(empty), 1);

        @(posedge clk); #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
